// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        HOLD
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide on
// operand magnitudes, one bit per cycle, sign applied on the final step.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_exception
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    logic             r_busy, r_is_div, r_neg, r_b_zero;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_opb;

    logic [WIDTH:0]     w_sum, w_shift, w_trial;
    logic [WIDTH-1:0]   w_mul_hi, w_mul_lo, w_div_hi, w_div_lo, w_quot;
    logic [2*WIDTH-1:0] w_prod, w_sprod;
    logic               w_qbit, w_mul_ovf, w_div_ovf;

    // Multiply step: {hi,lo} holds partial product and remaining multiplier bits.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

    // Divide step: hi is the remainder, lo shifts dividend out and quotient in.
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_opb};
    assign w_qbit   = !w_trial[WIDTH];
    assign w_div_hi = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_qbit};

    // The last iteration's next-state feeds the result directly, so the
    // top level captures it on the same edge the final bit is produced.
    assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign w_prod    = {w_mul_hi, w_mul_lo};
    assign w_sprod   = r_neg ? -w_prod : w_prod;
    assign w_quot    = r_neg ? -w_div_lo : w_div_lo;
    assign w_mul_ovf = w_sprod[2*WIDTH-1:WIDTH] != {WIDTH{w_sprod[WIDTH-1]}};
    // A positive quotient with the top bit set only arises from MIN / -1.
    assign w_div_ovf = !r_neg && w_div_lo[WIDTH-1] && !r_b_zero;

    assign o_result    = !r_is_div ? w_sprod[WIDTH-1:0] : (r_b_zero ? '0 : w_quot);
    assign o_overflow  = r_is_div ? w_div_ovf : w_mul_ovf;
    assign o_exception = r_is_div ? (w_div_ovf || r_b_zero) : w_mul_ovf;

    // NOTE: the iteration registers are reset as well, so an abort can never leave a stale done pulse behind.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_b_zero <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_b_zero <= (i_b == '0);
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= f_abs(i_a);
            r_opb    <= f_abs(i_b);
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            r_hi  <= r_is_div ? w_div_hi : w_mul_hi;
            r_lo  <= r_is_div ? w_div_lo : w_mul_lo;
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; defining ALU_SEQ_MULDIV_EN adds
// iterative signed multiply/divide, otherwise opcodes 6/7 are illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_valid, r_ne, r_lt, r_ovf, r_exc, r_cmp_ne, r_cmp_lt;

    logic [WIDTH-1:0] w_add, w_sub, w_res, w_md_result;
    logic             w_add_ovf, w_sub_ovf, w_ne, w_lt, w_ovf, w_exc;
    logic             w_is_mul, w_is_div, w_md_done, w_md_ovf, w_md_exc;

    assign w_add     = data_operandA + data_operandB;
    assign w_sub     = data_operandA - data_operandB;
    assign w_add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                       (w_add[WIDTH-1] != data_operandA[WIDTH-1]);
    assign w_sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                       (w_sub[WIDTH-1] != data_operandA[WIDTH-1]);
    assign w_ne      = |w_sub;
    assign w_lt      = w_sub[WIDTH-1] ^ w_sub_ovf;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_exc = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin w_res = w_add; w_ovf = w_add_ovf; end
            OP_SUB: begin w_res = w_sub; w_ovf = w_sub_ovf; end
            OP_AND: w_res = data_operandA & data_operandB;
            OP_OR:  w_res = data_operandA | data_operandB;
            OP_SLL: w_res = data_operandA << ctrl_shiftamt;
            OP_SRA: w_res = $signed(data_operandA) >>> ctrl_shiftamt;
            default: w_exc = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    assign w_is_mul = (ctrl_ALUopcode == OP_MUL);
    assign w_is_div = (ctrl_ALUopcode == OP_DIV);

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_start     (in_valid && in_ready && (w_is_mul || w_is_div)),
        .i_is_div    (w_is_div),
        .i_a         (data_operandA),
        .i_b         (data_operandB),
        .o_done      (w_md_done),
        .o_result    (w_md_result),
        .o_overflow  (w_md_ovf),
        .o_exception (w_md_exc)
    );
`else
    assign w_is_mul    = 1'b0;
    assign w_is_div    = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
    assign w_md_ovf    = 1'b0;
    assign w_md_exc    = 1'b0;
`endif

    // NOTE: all state and outputs change in one clocked block using non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ne     <= 1'b0;
            r_lt     <= 1'b0;
            r_ovf    <= 1'b0;
            r_exc    <= 1'b0;
            r_cmp_ne <= 1'b0;
            r_cmp_lt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_cmp_ne <= w_ne;
                    r_cmp_lt <= w_lt;
                    if (w_is_mul) begin
                        r_state <= MUL;
                    end else if (w_is_div) begin
                        r_state <= DIV;
                    end else begin
                        r_state  <= HOLD;
                        r_valid  <= 1'b1;
                        r_result <= w_res;
                        r_ne     <= w_ne;
                        r_lt     <= w_lt;
                        r_ovf    <= w_ovf;
                        r_exc    <= w_exc;
                    end
                end
                MUL, DIV: if (w_md_done) begin
                    r_state  <= HOLD;
                    r_valid  <= 1'b1;
                    r_result <= w_md_result;
                    r_ne     <= r_cmp_ne;
                    r_lt     <= r_cmp_lt;
                    r_ovf    <= w_md_ovf;
                    r_exc    <= w_md_exc;
                end
                HOLD: if (out_ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_valid;
    assign data_result = r_result;
    assign isNotEqual  = r_ne;
    assign isLessThan  = r_lt;
    assign overflow    = r_ovf;
    assign exception   = r_exc;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the processor's combinational ALU. Accepts one operation per valid/ready handshake, executes add/sub/and/or/shift in one cycle and signed multiply/divide iteratively, and holds the result with flags until the consumer takes it. It sits between the decode/operand-read stage and writeback, so the pipeline can stall on long operations.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width; derived, never overridden.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block can accept; equals (state == IDLE).
- `data_operandA`, `data_operandB` in WIDTH: two's-complement operands, sampled on accept.
- `ctrl_ALUopcode` in 5: operation, sampled on accept.
- `ctrl_shiftamt` in SHW: shift distance, sampled on accept.
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: consumer takes result.
- `data_result` out WIDTH: result.
- `isNotEqual`, `isLessThan`, `overflow`, `exception` out 1 each: flags registered with the result.

## Operation
- Accept occurs when `in_valid && in_ready`. Operands, opcode and shift amount are captured, so inputs may change the cycle after accept.
- Opcodes:
  - 0: A+B.
  - 1: A−B.
  - 2: A&B.
  - 3: A|B.
  - 4: A<<shamt (logical).
  - 5: A>>>shamt (arithmetic).
  - 6: signed multiply, low WIDTH bits of the product.
  - 7: signed divide, quotient truncated toward zero.
  - 8–31: illegal; result 0, `exception`=1.
- `isNotEqual` and `isLessThan` are computed from A−B on every opcode.
  - isLessThan = sign(A−B) XOR subtract-overflow.
  - isNotEqual = (A−B) ≠ 0.
- `overflow`:
  - Opcodes 0/1: signed overflow of the add/sub.
  - Opcode 6: upper product half is not the sign-extension of the low half.
  - Opcode 7: only for MIN/−1; result is MIN.
  - All other opcodes: 0.
- `exception`:
  - Opcode 6: equals `overflow`.
  - Opcode 7: 1 when B=0 (result 0) or when `overflow` is set.
  - Illegal opcodes: 1.
  - All other opcodes: 0.
- FSM states: IDLE, MUL, DIV, HOLD.
  - IDLE to HOLD on accept of opcodes 0–5 or 8–31.
  - IDLE to MUL on accept of opcode 6.
  - IDLE to DIV on accept of opcode 7.
  - MUL/DIV to HOLD after WIDTH iteration cycles.
  - HOLD to IDLE when `out_ready`=1.
- MUL: radix-2 shift-add on operand magnitudes, one bit per cycle; the sign is applied at the end.
- DIV: restoring division on magnitudes, one quotient bit per cycle; the sign is applied at the end.
- B=0 still runs WIDTH cycles; the latency is data-independent.

## Timing
- Reset values:
  - State is IDLE.
  - `out_valid`, `data_result` and all flags are 0.
  - `in_ready` is 1.
- Latency from accept edge to `out_valid`=1:
  - Opcodes 0–5 and illegal: 1 cycle.
  - Opcodes 6/7: WIDTH+1 cycles.
- `out_valid` and all outputs are held stable in HOLD until the cycle `out_ready`=1; the next accept is possible one cycle later.
- No accept while busy or holding; `in_ready`=0 in MUL, DIV and HOLD.
- `out_ready` outside HOLD is ignored.
- `reset_n` low mid-operation aborts immediately: outputs go to reset values and the in-flight result is discarded.
- Sustained throughput:
  - One single-cycle op per 2 cycles.
  - One mul/div per WIDTH+2 cycles.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: opcodes 6/7 behave as above, and the MUL/DIV states and the sub-module are instantiated.
- Not defined: opcodes 6/7 are treated as illegal (1-cycle, result 0, `exception`=1), and no iterative hardware is built.

## Structure
- Package `alu_seq_pkg` holds:
  - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRA=5, OP_MUL=6, OP_DIV=7.
  - FSM state enum: IDLE, MUL, DIV, HOLD.
- Sub-module `alu_seq_muldiv(WIDTH)` contains the iteration counter, partial-product/remainder registers and the sign fix-up. It takes start/op/operands and returns done, result and its overflow/exception flags.
- The top level contains the single-cycle datapath, FSM, output register and handshake.

## Test plan
- Add overflow, WIDTH=32: A=0x7FFFFFFF, B=1, op 0 → `out_valid` one cycle after accept; result 0x80000000; `overflow`=1; `isLessThan`=0; `isNotEqual`=1.
- Shift: A=0x80000010, shamt=4, op 5 → 0xF8000001; same operands, op 4 → 0x00000100.
- Multiply: A=−7, B=6, op 6 → 33 cycles later −42 (0xFFFFFFD6), flags 0. Then A=0x10000, B=0x10000 → `overflow`=1, `exception`=1.
- Divide: A=−7, B=2, op 7 → −3. Then B=0 → result 0, `exception`=1, still 33-cycle latency. Then A=0x80000000, B=−1 → 0x80000000, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles → `in_ready` stays 0 and outputs do not change. Then `out_ready`=1 → IDLE next cycle and a new accept succeeds.
- Reset mid-divide: deassert `reset_n` at iteration 10 → `out_valid`=0 and `in_ready`=1 immediately. Then a new op 0 completes normally.
